// File: rtl/des_rr_sched.sv
// des_rr_sched: round-robin front end that shares one des_comb core among
// N_REQ requesters. It runs one job at a time: grant, start pulse, wait for the
// core (with a watchdog), then a response tagged with the requester index.
module des_rr_sched #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*64-1:0]   req_data,
    input  logic [N_REQ*64-1:0]   req_key,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  core_start,
    output logic [63:0]           core_desIn,
    output logic [63:0]           core_keyIn,
    input  logic                  core_ready,
    input  logic [63:0]           core_desOut,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  resp_err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Last WAIT cycle index; the abort fires at the end of this cycle.
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);

    state_t            state_r;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [15:0]       wd_cnt_r;
    logic              core_start_r;
    logic [63:0]       core_des_r;
    logic [63:0]       core_key_r;
    logic              resp_valid_r;
    logic [63:0]       resp_data_r;
    logic [ID_W-1:0]   resp_id_r;
    logic              resp_err_r;
    logic              busy_r;

    logic              grant_found_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [ID_W-1:0]   cand_s;
    logic              hit_s;
    logic [N_REQ-1:0]  grant_onehot_s;
    logic [N_REQ-1:0]  req_ready_s;
    logic [63:0]       sel_data_s;
    logic [63:0]       sel_key_s;

    // Rotating priority search: first valid requester at or after rr_ptr wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        hit_s         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s        = ID_W'((int'(rr_ptr_r) + k) % N_REQ);
            hit_s         = ~grant_found_s & req_valid[cand_s];
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
        grant_onehot_s = {{(N_REQ-1){1'b0}}, grant_found_s} << grant_idx_s;
        sel_data_s     = req_data[{grant_idx_s, 6'd0} +: 64];
        sel_key_s      = req_key[{grant_idx_s, 6'd0} +: 64];
    end

    // Accept pulse: only while idle and out of reset, so it pairs with the grant edge.
    always_comb begin
        if ((state_r == ST_IDLE) && !rst) begin
            req_ready_s = grant_onehot_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // Job sequencer: grant, one-cycle start, watchdog wait, hold response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            wd_cnt_r     <= 16'd0;
            core_start_r <= 1'b0;
            core_des_r   <= 64'd0;
            core_key_r   <= 64'd0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 64'd0;
            resp_id_r    <= '0;
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        core_des_r   <= sel_data_s;
                        core_key_r   <= sel_key_s;
                        resp_id_r    <= grant_idx_s;
                        core_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    core_start_r <= 1'b0;
                    wd_cnt_r     <= 16'd0;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    wd_cnt_r <= wd_cnt_r + 16'd1;
                    // The first WAIT cycle (count 0) may still see ready from the previous job.
                    if (core_ready && (wd_cnt_r != 16'd0)) begin
                        resp_data_r  <= core_desOut;
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else if (wd_cnt_r == WD_LAST) begin
                        resp_data_r  <= 64'd0;
                        resp_err_r   <= 1'b1;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        rr_ptr_r     <= (resp_id_r == ID_W'(N_REQ - 1)) ? '0 : resp_id_r + 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    core_start_r <= 1'b0;
                    resp_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign core_start = core_start_r;
    assign core_desIn = core_des_r;
    assign core_keyIn = core_key_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_id    = resp_id_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_des_rr_sched.sv
// Bench for des_rr_sched: a behavioural stand-in for des_comb, a scoreboard of
// expected responses, and one task per scenario.
module tb_des_rr_sched;

    localparam int N_REQ       = 4;
    localparam int ID_W        = 2;
    localparam int TIMEOUT_CYC = 64;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic            err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*64-1:0]  req_data;
    logic [N_REQ*64-1:0]  req_key;
    logic [N_REQ-1:0]     req_ready;
    logic                 core_start;
    logic [63:0]          core_desIn;
    logic [63:0]          core_keyIn;
    logic                 core_ready = 1'b0;
    logic [63:0]          core_desOut = 64'd0;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [63:0]          resp_data;
    logic [ID_W-1:0]      resp_id;
    logic                 resp_err;
    logic                 busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    int   core_lat  = 3;
    bit   core_dead = 1'b0;
    bit   core_keep = 1'b0;
    int   core_cnt  = 0;

    des_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_key(req_key), .req_ready(req_ready),
        .core_start(core_start), .core_desIn(core_desIn), .core_keyIn(core_keyIn),
        .core_ready(core_ready), .core_desOut(core_desOut),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Known DES vector for the classic test pair, a cheap mixing function otherwise.
    function automatic logic [63:0] core_f(input logic [63:0] d, input logic [63:0] k);
        if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1) return 64'h85E813540F0AB405;
        return d ^ {k[31:0], k[63:32]} ^ 64'hA5A55A5A0F0FF0F0;
    endfunction

    function automatic logic [63:0] pt(input int i);
        return 64'h0F1E2D3C4B5A6978 ^ {8{8'(i * 17 + 3)}};
    endfunction

    function automatic logic [63:0] ky(input int i);
        return 64'hFEDCBA9876543210 + 64'(i * 4099);
    endfunction

    // Core stand-in: result and ready appear core_lat cycles after start.
    always @(posedge clk) begin
        if (core_start) begin
            if (!core_keep) core_ready <= 1'b0;
            core_cnt <= core_lat;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !core_dead) begin
                core_ready  <= 1'b1;
                core_desOut <= core_f(core_desIn, core_keyIn);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [63:0] d, input logic [63:0] k);
        req_data[i*64 +: 64] = d;
        req_key[i*64 +: 64]  = k;
    endtask

    task automatic wait_resp(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick(); #1;
            if (resp_valid) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; resp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, pt(i), ky(i));
        repeat (3) tick();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++;
        if ({core_start, resp_valid, resp_err, busy} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: start/valid/err/busy=%b want 0000", {core_start, resp_valid, resp_err, busy});
        end
        checks++;
        if (core_desIn !== 64'd0 || core_keyIn !== 64'd0) begin
            failures++; $display("FAIL reset_core_bus: desIn=%h keyIn=%h want 0", core_desIn, core_keyIn);
        end
        checks++;
        if (resp_data !== 64'd0 || resp_id !== 2'd0) begin
            failures++; $display("FAIL reset_resp: data=%h id=%0d want 0", resp_data, resp_id);
        end
        tick(); rst = 1'b0; req_valid = 4'b0000;
    endtask

    task automatic test_single();
        bit   got;
        exp_t e;
        tick();
        core_lat = 3; core_dead = 1'b0; core_keep = 1'b0; resp_ready = 1'b1;
        set_req(0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
        req_valid = 4'b0001;
        sb.push_back('{2'd0, 64'h85E813540F0AB405, 1'b0});
        #1;
        checks++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin failures++; $display("FAIL t1_grant: ready=%b busy=%b want 0001/0", req_ready, busy); end
        tick(); req_valid = 4'b0000; #1;
        checks++;
        if (core_start !== 1'b1 || req_ready !== 4'b0000 || busy !== 1'b1) begin
            failures++; $display("FAIL t1_issue: start=%b ready=%b busy=%b want 1/0000/1", core_start, req_ready, busy);
        end
        checks++;
        if (core_desIn !== 64'h0123456789ABCDEF || core_keyIn !== 64'h133457799BBCDFF1) begin
            failures++; $display("FAIL t1_core_bus: desIn=%h keyIn=%h want 0123456789abcdef/133457799bbcdff1", core_desIn, core_keyIn);
        end
        tick(); #1;
        checks++;
        if (core_start !== 1'b0) begin failures++; $display("FAIL t1_start_width: start=%b want 0", core_start); end
        wait_resp(50, got);
        checks++;
        if (!got) begin failures++; $display("FAIL t1_timeout: resp_valid=0 want 1 within 50 cycles"); end
        else if (sb.size() == 0) begin failures++; $display("FAIL t1_resp: id=%0d with empty scoreboard", resp_id); end
        else begin
            e = sb.pop_front();
            if ({resp_id, resp_data, resp_err} !== {e.id, e.data, e.err}) begin
                failures++; $display("FAIL t1_resp: id=%0d data=%h err=%b want id=%0d data=%h err=%b", resp_id, resp_data, resp_err, e.id, e.data, e.err);
            end
        end
        tick(); #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t1_release: valid=%b busy=%b want 0/0", resp_valid, busy); end
    endtask

    task automatic test_round_robin();
        int   nresp = 0, ngrant = 0, viol = 0;
        exp_t e;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        core_lat = 2; resp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_req(i, pt(i), ky(i));
        for (int j = 0; j < 5; j++) sb.push_back('{2'(j % N_REQ), core_f(pt(j % N_REQ), ky(j % N_REQ)), 1'b0});
        req_valid = 4'b1111;
        for (int c = 0; c < 300 && nresp < 5; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                ngrant++;
                if ($countones(req_ready) != 1 || busy) viol++;
            end
            if (resp_valid) begin
                nresp++;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL t2_resp: id=%0d with empty scoreboard", resp_id); end
                else begin
                    e = sb.pop_front();
                    if ({resp_id, resp_data, resp_err} !== {e.id, e.data, e.err}) begin
                        failures++; $display("FAIL t2_resp%0d: id=%0d data=%h err=%b want id=%0d data=%h err=%b", nresp, resp_id, resp_data, resp_err, e.id, e.data, e.err);
                    end
                end
                if (nresp == 5) req_valid = 4'b0000;
            end
            if (nresp < 5) tick();
        end
        checks++;
        if (nresp != 5) begin failures++; $display("FAIL t2_count: responses=%0d want 5", nresp); end
        checks++;
        if (ngrant != 5) begin failures++; $display("FAIL t2_grants: req_ready pulses=%0d want 5", ngrant); end
        checks++;
        if (viol != 0) begin failures++; $display("FAIL t2_ready_rule: violations=%0d want 0", viol); end
    endtask

    task automatic test_backpressure();
        bit   got;
        int   bad = 0;
        exp_t e;
        tick();
        core_lat = 2; resp_ready = 1'b0;
        set_req(1, pt(5), ky(5));
        set_req(3, pt(6), ky(6));
        sb.push_back('{2'd1, core_f(pt(5), ky(5)), 1'b0});
        sb.push_back('{2'd3, core_f(pt(6), ky(6)), 1'b0});
        req_valid = 4'b0010;
        tick(); req_valid = 4'b0000;
        wait_resp(50, got);
        checks++;
        if (!got) begin failures++; $display("FAIL t3_timeout: resp_valid=0 want 1 within 50 cycles"); end
        req_valid = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            tick(); #1;
            if (!resp_valid || sb.size() == 0) bad++;
            else if ({resp_id, resp_data, resp_err} !== {sb[0].id, sb[0].data, sb[0].err}) bad++;
            if (req_ready !== 4'b0000 || core_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL t3_hold: unstable/illegal cycles=%0d want 0", bad); end
        resp_ready = 1'b1;
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL t3_resp: id=%0d with empty scoreboard", resp_id); end
        else begin
            e = sb.pop_front();
            if (resp_valid !== 1'b1 || {resp_id, resp_data, resp_err} !== {e.id, e.data, e.err}) begin
                failures++; $display("FAIL t3_resp: valid=%b id=%0d data=%h err=%b want 1 id=%0d data=%h err=%b", resp_valid, resp_id, resp_data, resp_err, e.id, e.data, e.err);
            end
        end
        tick(); #1;
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL t3_regrant: ready=%b want 1000", req_ready); end
        tick(); req_valid = 4'b0000;
        wait_resp(50, got);
        checks++;
        if (!got) begin failures++; $display("FAIL t3_timeout2: resp_valid=0 want 1 within 50 cycles"); end
        else if (sb.size() == 0) begin failures++; $display("FAIL t3_resp2: id=%0d with empty scoreboard", resp_id); end
        else begin
            e = sb.pop_front();
            if ({resp_id, resp_data, resp_err} !== {e.id, e.data, e.err}) begin
                failures++; $display("FAIL t3_resp2: id=%0d data=%h err=%b want id=%0d data=%h err=%b", resp_id, resp_data, resp_err, e.id, e.data, e.err);
            end
        end
    endtask

    // One job through the stand-in core; checks result and the WAIT length.
    task automatic test_wd_job(input string nm, input int idx, input int lat, input bit dead,
                               input bit keep, input int want_lat, input logic [63:0] want_data,
                               input logic want_err);
        bit   got;
        int   s;
        exp_t e;
        tick();
        core_lat = lat; core_dead = dead; core_keep = keep; resp_ready = 1'b1;
        set_req(idx, pt(idx + 8), ky(idx + 8));
        sb.push_back('{2'(idx), want_data, want_err});
        req_valid = 4'(1 << idx);
        #1;
        checks++;
        if (req_ready !== 4'(1 << idx)) begin failures++; $display("FAIL %s_grant: ready=%b want %b", nm, req_ready, 4'(1 << idx)); end
        tick(); req_valid = 4'b0000; #1;
        s = cyc;
        wait_resp(200, got);
        checks++;
        if (!got) begin failures++; $display("FAIL %s_timeout: resp_valid=0 want 1 within 200 cycles", nm); end
        else if (cyc - s != want_lat) begin failures++; $display("FAIL %s_latency: issue->resp=%0d want %0d", nm, cyc - s, want_lat); end
        checks++;
        if (!got || sb.size() == 0) begin failures++; $display("FAIL %s_resp: no response or empty scoreboard", nm); end
        else begin
            e = sb.pop_front();
            if ({resp_id, resp_data, resp_err} !== {e.id, e.data, e.err}) begin
                failures++; $display("FAIL %s_resp: id=%0d data=%h err=%b want id=%0d data=%h err=%b", nm, resp_id, resp_data, resp_err, e.id, e.data, e.err);
            end
        end
        core_dead = 1'b0; core_keep = 1'b0;
    endtask

    task automatic test_watchdog();
        test_wd_job("t4_abort", 2, 3, 1'b1, 1'b0, TIMEOUT_CYC + 1, 64'd0, 1'b1);
        test_wd_job("t4_last_cycle", 3, TIMEOUT_CYC - 1, 1'b0, 1'b0, TIMEOUT_CYC + 1,
                    core_f(pt(11), ky(11)), 1'b0);
    endtask

    task automatic test_stale_ready();
        test_wd_job("t5_stale", 1, 1, 1'b0, 1'b1, 3, core_f(pt(9), ky(9)), 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        bit   got;
        exp_t e;
        tick();
        core_lat = 20; resp_ready = 1'b1;
        set_req(0, pt(1), ky(1));
        req_valid = 4'b0001;
        tick(); req_valid = 4'b0000;
        repeat (4) tick();
        rst = 1'b1; set_req(2, pt(12), ky(12)); req_valid = 4'b0100;
        tick(); rst = 1'b0; #1;
        checks++;
        if ({core_start, resp_valid, resp_err, busy} !== 4'b0000 || resp_data !== 64'd0 || resp_id !== 2'd0) begin
            failures++; $display("FAIL t6_reset_outs: start/valid/err/busy=%b data=%h id=%0d want 0", {core_start, resp_valid, resp_err, busy}, resp_data, resp_id);
        end
        checks++;
        if (core_desIn !== 64'd0 || core_keyIn !== 64'd0) begin
            failures++; $display("FAIL t6_reset_core: desIn=%h keyIn=%h want 0", core_desIn, core_keyIn);
        end
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL t6_grant: ready=%b want 0100", req_ready); end
        sb.push_back('{2'd2, core_f(pt(12), ky(12)), 1'b0});
        tick(); req_valid = 4'b0000; #1;
        checks++;
        if (core_start !== 1'b1 || core_desIn !== pt(12)) begin
            failures++; $display("FAIL t6_issue: start=%b desIn=%h want 1/%h", core_start, core_desIn, pt(12));
        end
        wait_resp(60, got);
        checks++;
        if (!got || sb.size() == 0) begin failures++; $display("FAIL t6_resp: no response within 60 cycles"); end
        else begin
            e = sb.pop_front();
            if ({resp_id, resp_data, resp_err} !== {e.id, e.data, e.err}) begin
                failures++; $display("FAIL t6_resp: id=%0d data=%h err=%b want id=%0d data=%h err=%b", resp_id, resp_data, resp_err, e.id, e.data, e.err);
            end
        end
        repeat (30) begin
            tick(); #1;
            checks++;
            if (resp_valid !== 1'b0) begin failures++; $display("FAIL t6_ghost: resp_valid=%b id=%0d want 0", resp_valid, resp_id); end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'b0000; req_data = '0; req_key = '0; resp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_stale_ready();
        test_reset_mid_wait();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: leftover=%0d want 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
